// File: rtl/gate_tester_if.sv
// gate_tester_if: run control, stimulus, gate responses and result bundle
interface gate_tester_if;
  logic       start;
  logic       a;
  logic       b;
  logic       dut_and;
  logic       dut_not;
  logic       dut_or;
  logic       dut_xor;
  logic       dut_xnor;
  logic       dut_nand;
  logic       dut_nor;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [6:0] err_gate;
  logic [2:0] err_count;
  modport master (
    input  start, dut_and, dut_not, dut_or, dut_xor, dut_xnor, dut_nand, dut_nor,
    output a, b, busy, done, pass, fail_vec, err_gate, err_count
  );
  modport slave (
    output start, dut_and, dut_not, dut_or, dut_xor, dut_xnor, dut_nand, dut_nor,
    input  a, b, busy, done, pass, fail_vec, err_gate, err_count
  );
endinterface

// File: rtl/gate_tester.sv
// gate_tester: walks the 2-input truth table and checks seven gate responses
module gate_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  gate_tester_if.master io
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d, pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [6:0] err_gate_q, err_gate_d, exp_w, obs_w, mis_w;
  logic [2:0] err_count_q, err_count_d;
  assign exp_w = {idx_q[1] & idx_q[0], ~idx_q[1], idx_q[1] | idx_q[0], idx_q[1] ^ idx_q[0],
                  ~(idx_q[1] ^ idx_q[0]), ~(idx_q[1] & idx_q[0]), ~(idx_q[1] | idx_q[0])};
  assign obs_w = {io.dut_and, io.dut_not, io.dut_or, io.dut_xor, io.dut_xnor, io.dut_nand, io.dut_nor};
  assign mis_w = obs_w ^ exp_w;
  // a/b are loaded on entry to DRIVE so the vector is visible for SETTLE+2 cycles up to CHECK
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    err_gate_d  = err_gate_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d     = DRIVE;
        idx_d       = 2'd0;
        a_d         = 1'b0;
        b_d         = 1'b0;
        pass_d      = 1'b0;
        fail_vec_d  = 4'd0;
        err_gate_d  = 7'd0;
        err_count_d = 3'd0;
      end
      DRIVE: begin
        cnt_d   = 4'(SETTLE);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? CHECK : WAIT;
      end
      CHECK: begin
        if (|mis_w) begin
          fail_vec_d[idx_q] = 1'b1;
          err_gate_d        = err_gate_q | mis_w;
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (fail_vec_d == 4'd0);
        end else begin
          state_d    = DRIVE;
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      err_gate_q  <= 7'd0;
      err_count_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      err_gate_q  <= err_gate_d;
      err_count_q <= err_count_d;
    end
  end
  assign io.a         = a_q;
  assign io.b         = b_q;
  assign io.busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign io.done      = (state_q == DONE);
  assign io.pass      = pass_q;
  assign io.fail_vec  = fail_vec_q;
  assign io.err_gate  = err_gate_q;
  assign io.err_count = err_count_q;
endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001: Parameter SETTLE, default 2, number of wait cycles between driving a/b and sampling DUT outputs; legal range 1..15.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: start  input  1  request a full truth-table run; sampled only in IDLE.
REQ-005: a, b  output  1 each  registered stimulus to the gate block under test.
REQ-006: dut_and, dut_not, dut_or, dut_xor, dut_xnor, dut_nand, dut_nor  input  1 each  responses from the gate block.
REQ-007: busy  output  1  high from the DRIVE state through the CHECK state, inclusive.
REQ-008: done  output  1  single-cycle pulse at end of run.
REQ-009: pass  output  1  run result; 1 only if every vector matched.
REQ-010: fail_vec  output  4  bit i set if vector i ({a,b}=i) had any mismatch.
REQ-011: err_gate  output  7  sticky OR of mismatched gate bits: [6]and [5]not [4]or [3]xor [2]xnor [1]nand [0]nor.
REQ-012: err_count  output  3  number of failing vectors, 0..4.

Function
REQ-013: The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK and DONE; it SHALL hold a 2-bit vector index idx and a settle counter.
REQ-014: IDLE: a=b=0, busy=0; start=1 -> clear fail_vec, err_gate, err_count and pass; set idx=0; go to DRIVE.
REQ-015: DRIVE (1 cycle): register {a,b}=idx; load the settle counter; go to WAIT.
REQ-016: WAIT (exactly SETTLE cycles): hold a/b; count down; go to CHECK.
REQ-017: CHECK (1 cycle): compare the DUT inputs with expected values.
  - Expected and=a&b, not=~a, or=a|b, xor=a^b, xnor=~(a^b), nand=~(a&b), nor=~(a|b), all computed from idx.
  - On any mismatch: set fail_vec[idx], OR the mismatch mask into err_gate, and increment err_count.
  - If idx==3 go to DONE; otherwise increment idx and go to DRIVE.
REQ-018: Vector order SHALL be 00, 01, 10, 11; each vector SHALL be held on a/b for SETTLE+2 cycles.
REQ-019: DONE (1 cycle): done=1; pass=(fail_vec==0), including the update from the final CHECK; a=b=0; go to IDLE.
REQ-020: Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+4*(SETTLE+2).
REQ-021: pass, fail_vec, err_gate and err_count SHALL hold their values after DONE until the next accepted start or rst.
REQ-022: start SHALL be ignored in DRIVE, WAIT, CHECK and DONE; results SHALL NOT be cleared mid-run.
REQ-023: start held high continuously SHALL begin a new run on the first IDLE cycle after DONE.
REQ-024: err_count SHALL NOT wrap, because the maximum value is 4.

Reset
REQ-025: rst=1 at a rising edge SHALL force, in any state:
  - state=IDLE, idx=0
  - a=b=0, busy=0, done=0, pass=0
  - fail_vec=0, err_gate=0, err_count=0
REQ-026: rst SHALL take priority over start in the same cycle.
REQ-027: A run aborted by reset SHALL NOT produce a done pulse.

Verification
REQ-028: Correct gate model, SETTLE=2, one start pulse -> a/b sequence 00, 01, 10, 11, 4 cycles each; done 16 cycles after start; pass=1; fail_vec=0000; err_gate=0000000; err_count=0.
REQ-029: nand output stuck at 0 -> fail_vec=0111 (vectors 0..2), err_gate=0000010, err_count=3, pass=0.
REQ-030: xor and xnor outputs swapped -> fail_vec=1111, err_gate=0001100, err_count=4, pass=0.
REQ-031: start pulsed again during WAIT of vector 1 -> ignored; run completes at the original cycle; results are not cleared.
REQ-032: rst during WAIT of vector 2 -> next edge all outputs at reset values, no done pulse; a later start runs a fresh full sequence with a correct result.
REQ-033: SETTLE=1, start held high -> back-to-back runs, each 12 cycles plus DONE and IDLE cycles; done pulses exactly once per run.
